// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule.
package aes_pkg;

  typedef logic [3:0][3:0][7:0] aes_block_t;

  localparam logic [7:0] AES_RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {IDLE, GEN, EMIT} ks_state_e;

endpackage

// File: rtl/aes_key_sched_if.sv
// Key-in / round-key-out handshake bundle; master drives keys and consumes round keys.
interface aes_key_sched_if;
  import aes_pkg::*;

  logic       key_valid;
  logic       key_ready;
  aes_block_t key;
  logic       rk_valid;
  logic       rk_ready;
  aes_block_t rk_data;
  logic [3:0] rk_idx;
  logic       rk_last;

  modport master (
    output key_valid, key, rk_ready,
    input  key_ready, rk_valid, rk_data, rk_idx, rk_last
  );

  modport slave (
    input  key_valid, key, rk_ready,
    output key_ready, rk_valid, rk_data, rk_idx, rk_last
  );

endinterface

// File: rtl/aes_key_word_gen.sv
// One AES-128 key-expansion step: round key r-1 plus round number r gives round key r.
module aes_key_word_gen
  import aes_pkg::*;
(
  input  aes_block_t rk_in,
  input  logic [3:0] rnd,
  output aes_block_t rk_out
);

  logic [3:0][7:0] rot;
  logic [3:0][7:0] sub;
  logic [7:0]      rc;
  logic [31:0]     t, w0n, w1n, w2n, w3n;

  // RotWord on w3 (rk_in[0]): byte order b0 b1 b2 b3 -> b1 b2 b3 b0.
  assign rot = {rk_in[0][2], rk_in[0][1], rk_in[0][0], rk_in[0][3]};

  sub_bytes #(.N(4)) u_sub (
    .din  (rot),
    .dout (sub)
  );

  assign rc  = (rnd >= 4'd1 && rnd <= 4'd10) ? AES_RCON[rnd] : 8'h00;
  assign t   = sub ^ {rc, 24'h0};
  assign w0n = rk_in[3] ^ t;
  assign w1n = rk_in[2] ^ w0n;
  assign w2n = rk_in[1] ^ w1n;
  assign w3n = rk_in[0] ^ w2n;

  assign rk_out = {w0n, w1n, w2n, w3n};

endmodule

// File: rtl/sub_bytes.sv
// AES S-box substitution applied independently to N bytes (combinational).
module sub_bytes #(
  parameter int N = 16
) (
  input  logic [N-1:0][7:0] din,
  output logic [N-1:0][7:0] dout
);

  // Byte x lives at bits [(255-x)*8 +: 8]; 255-x is simply ~x.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar i = 0; i < N; i++) begin : g_sb
    assign dout[i] = SBOX[{~din[i], 3'b000} +: 8];
  end

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key schedule streaming round keys 0..NR over valid/ready.
// Build option AES_KEYSCHED_REVERSE_EN: precompute all keys, then emit NR..0.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input logic            clk,
  input logic            rst,
  aes_key_sched_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  ks_state_e  state_p0;
  logic [3:0] cnt_p0;
  aes_block_t rk_p0;
  logic       vld_p0;
  logic       rdy_p0;
  logic       last_p0;
  aes_block_t nxt;
  aes_block_t gen_in;

  aes_key_word_gen u_gen (
    .rk_in  (gen_in),
    .rnd    (cnt_p0 + 4'd1),
    .rk_out (nxt)
  );

`ifdef AES_KEYSCHED_REVERSE_EN
  aes_block_t wk_p0;
  aes_block_t tbl_p0 [0:NR];

  assign gen_in = wk_p0;

  // Working key and key table carry data only; they are reloaded per job.
  always_ff @(posedge clk) begin
    if (state_p0 == IDLE) begin
      wk_p0 <= bus.key;
    end else if (state_p0 == GEN) begin
      tbl_p0[cnt_p0] <= wk_p0;
      wk_p0          <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      rk_p0    <= '0;
      vld_p0   <= 1'b0;
      rdy_p0   <= 1'b1;
      last_p0  <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: if (bus.key_valid) begin
          cnt_p0   <= '0;
          rdy_p0   <= 1'b0;
          state_p0 <= GEN;
        end
        GEN: if (cnt_p0 == LAST_IDX) begin
          rk_p0    <= wk_p0;
          vld_p0   <= 1'b1;
          last_p0  <= 1'b0;
          state_p0 <= EMIT;
        end else begin
          cnt_p0 <= cnt_p0 + 4'd1;
        end
        EMIT: if (bus.rk_ready) begin
          if (cnt_p0 == 4'd0) begin
            vld_p0   <= 1'b0;
            rdy_p0   <= 1'b1;
            last_p0  <= 1'b0;
            state_p0 <= IDLE;
          end else begin
            cnt_p0  <= cnt_p0 - 4'd1;
            rk_p0   <= tbl_p0[cnt_p0 - 4'd1];
            last_p0 <= (cnt_p0 == 4'd1);
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end
`else
  assign gen_in = rk_p0;

  // The output register doubles as the single working key register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      rk_p0    <= '0;
      vld_p0   <= 1'b0;
      rdy_p0   <= 1'b1;
      last_p0  <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: if (bus.key_valid) begin
          rk_p0    <= bus.key;
          cnt_p0   <= '0;
          vld_p0   <= 1'b1;
          rdy_p0   <= 1'b0;
          last_p0  <= 1'b0;
          state_p0 <= EMIT;
        end
        EMIT: if (bus.rk_ready) begin
          if (cnt_p0 == LAST_IDX) begin
            vld_p0   <= 1'b0;
            rdy_p0   <= 1'b1;
            last_p0  <= 1'b0;
            state_p0 <= IDLE;
          end else begin
            rk_p0   <= nxt;
            cnt_p0  <= cnt_p0 + 4'd1;
            last_p0 <= (cnt_p0 + 4'd1 == LAST_IDX);
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end
`endif

  assign bus.key_ready = rdy_p0;
  assign bus.rk_valid  = vld_p0;
  assign bus.rk_data   = rk_p0;
  assign bus.rk_idx    = cnt_p0;
  assign bus.rk_last   = last_p0;

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Sequential AES-128 key-schedule stage. Accepts one 128-bit cipher key per job and streams the 11 round keys over a valid/ready interface, one round key per accepted beat. It sits directly upstream of the round datapath and drives the `key` input of the round stages, including the final reduced round, which consumes `rk_idx` 10. It expands on the fly with one 128-bit working register, with no full key table, unless the reverse-order build option is compiled in.

## Interface
- `NR`, default 10: number of rounds; `NR+1` round keys are emitted. Only 10 (AES-128) is supported.
- `clk` input, 1: single clock; all logic is on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `key_valid` input, 1: `key` is presented.
- `key_ready` output, 1: block is idle and will accept a key.
- `key` input, [3:0][3:0][7:0]: cipher key. Flattened bits [127:120] are FIPS-197 byte 0; word `w0` = `key[3]`, `w3` = `key[0]`.
- `rk_valid` output, 1: round key is present on `rk_data`.
- `rk_ready` input, 1: downstream consumes the round key.
- `rk_data` output, [3:0][3:0][7:0]: round key, same byte layout as `key`.
- `rk_idx` output, 4: round number of `rk_data` (0..10).
- `rk_last` output, 1: high with the final round key of the job.

## Operation
- Handshakes:
  - The input handshake fires on `key_valid && key_ready`.
  - The output handshake fires on `rk_valid && rk_ready`.
- FSM states:
  - IDLE: `key_ready`=1, `rk_valid`=0. On an input handshake, load the working register with `key`, set the counter to 0, and go to EMIT.
  - EMIT: `rk_valid`=1, `rk_data` = working register, `rk_idx` = counter.
    - On an output handshake with counter < 10: working register <= next round key, counter++.
    - On an output handshake with counter == 10: go to IDLE.
- Next round key, with `t = SubWord(RotWord(w3)) ^ {rcon[counter+1], 24'h0}`:
  - `w0' = w0 ^ t`
  - `w1' = w1 ^ w0'`
  - `w2' = w2 ^ w1'`
  - `w3' = w3 ^ w2'`
- `rcon` sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- `rk_last` = (counter == 10) in EMIT.
- Backpressure: while `rk_valid && !rk_ready`, `rk_data`, `rk_idx` and `rk_last` are held stable.
- `key_valid` is ignored outside IDLE, and `key` is not sampled outside IDLE.
- Reset mid-job discards the job and returns to IDLE. The next key starts a fresh schedule at index 0.
- Reset values: `key_ready`=1, `rk_valid`=0, `rk_idx`=0, `rk_last`=0, `rk_data`=0.

## Timing
- Key accepted at edge N: `rk_idx` 0 is valid in cycle N+1.
- Under continuous `rk_ready`=1, one round key per cycle; `rk_idx` 10 appears in cycle N+11.
- Final output handshake at edge M: `key_ready`=1 in cycle M+1. Back-to-back jobs therefore have a 1-cycle bubble.
- `rk_valid` and `rk_data` are registered outputs. There is no combinational path from `rk_ready` or `key_valid` to any output.
- The next-key logic is one combinational step: 4 S-box lookups plus XOR chain, fitting in one cycle.

## Configuration
- `AES_KEYSCHED_REVERSE_EN` undefined: forward order as above. Storage is one 128-bit register.
- `AES_KEYSCHED_REVERSE_EN` defined: decryption order.
  - An extra state GEN follows IDLE. It writes all 11 keys into an 11x128 register file, one per cycle (keys 0..10, 11 cycles, `rk_valid`=0).
  - EMIT then emits `rk_idx` 10 down to 0; `rk_last` is high with `rk_idx` 0.
  - Key accepted at edge N: first `rk_valid` in cycle N+12.
  - Backpressure and reset rules are unchanged.

## Structure
- Package `aes_pkg` holds:
  - `typedef logic [3:0][3:0][7:0] aes_block_t`
  - `localparam logic [7:0] AES_RCON [1:10]`
  - the FSM state enum `ks_state_e` (IDLE, GEN, EMIT)
- Sub-module: `aes_key_word_gen`, which is combinational. It takes the current round key and round number and produces the next round key. It instantiates the existing `sub_bytes` on the rotated `w3` row for SubWord.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with `rk_ready`=1:
  - `rk_idx` 0 = key in cycle N+1.
  - `rk_idx` 1 = a0fafe1788542cb123a339392a6c7605.
  - `rk_idx` 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_last`=1 in cycle N+11.
- Random `rk_ready` toggling on the same key:
  - `rk_data` and `rk_idx` stay stable while stalled.
  - All 11 keys match the model, in order, with no duplicates or drops.
- `key_valid` held high for the whole job with a different key:
  - `key_ready`=0 throughout and the second key is not accepted mid-job.
  - It is accepted in the cycle after the `rk_last` handshake, and the next job starts at `rk_idx` 0.
- Assert `rst` for 1 cycle while `rk_idx`=5 is stalled:
  - Next cycle `rk_valid`=0, `key_ready`=1.
  - A new key of all zeros yields `rk_idx` 1 = 62636363626363636263636362636363.
- `AES_KEYSCHED_REVERSE_EN` build with the FIPS key:
  - No `rk_valid` for 11 cycles.
  - First beat is `rk_idx` 10 = d014f9a8…; last beat is `rk_idx` 0 = key with `rk_last`=1.
